// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared definitions for the pipelined adder.
//   slice_width() - bits handled by one pipeline stage (WIDTH / STAGES)
//   cfg_ok()      - legality of a WIDTH/STAGES pair, checked at elaboration
//   stage_t       - per-stage pipeline record (valid, carry, sum, operands)
// Record fields are sized to MaxWidth; WIDTH must not exceed it. Unused upper
// bits stay zero and are trimmed by synthesis.
package pipe_adder_pkg;

   localparam int unsigned MaxWidth = 64;

   function automatic int unsigned slice_width(input int unsigned width,
                                               input int unsigned stages);
      return (stages == 0) ? width : width / stages;
   endfunction

   function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
      return (stages >= 1) && (width >= stages) && ((width % stages) == 0) &&
             (width <= MaxWidth);
   endfunction

   // sum holds the already-added low slices (deskew); opa/opb still carry the
   // not-yet-added high slices (skew).
   typedef struct packed {
      logic                valid;
      logic                carry;
      logic [MaxWidth-1:0] sum;
      logic [MaxWidth-1:0] opa;
      logic [MaxWidth-1:0] opb;
   } stage_t;

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
//   in_valid/in_ready   - operand transfer (A, B, Cin)
//   out_valid/out_ready - result transfer (S, Cout, Ovf)
//   master - operand producer / result consumer side
//   slave  - the adder
// Ovf exists only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             Cout;
`ifdef PIPE_ADDER_OVF_EN
   logic             Ovf;
`endif

   modport master (
      output in_valid, A, B, Cin, out_ready,
`ifdef PIPE_ADDER_OVF_EN
      input  Ovf,
`endif
      input  in_ready, out_valid, S, Cout
   );

   modport slave (
      input  in_valid, A, B, Cin, out_ready,
`ifdef PIPE_ADDER_OVF_EN
      output Ovf,
`endif
      output in_ready, out_valid, S, Cout
   );

endinterface

// File: rtl/adder_slice.sv
// adder_slice: WIDTH-bit combinational ripple-carry adder built from full_adder.
//   A, B - addends
//   Cin  - carry-in
//   S    - sum (WIDTH bits)
//   Cout - carry-out of the top bit
module adder_slice #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);
   // Carries are kept per-bit in each generate scope so the ripple chain is
   // not a self-dependent vector.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic ci;
      logic co;
      if (i == 0) begin : g_lsb
         assign ci = Cin;
      end else begin : g_rest
         assign ci = g_bit[i-1].co;
      end
      full_adder u_fa (
         .a   (A[i]),
         .b   (B[i]),
         .cin (ci),
         .s   (S[i]),
         .cout(co)
      );
   end

   assign Cout = g_bit[WIDTH-1].co;
endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full-adder cell.
//   a, b, cin - addends and carry-in
//   s, cout   - sum and carry-out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: elastic, pipelined WIDTH-bit ripple-carry adder.
// Operands are split into STAGES slices of SLICE = WIDTH/STAGES bits; stage k
// adds slice k using the carry registered by stage k-1, so carry ripples one
// slice per clock. Latency STAGES, throughput one op per cycle.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - pipe_adder_if.slave: in_valid/in_ready/A/B/Cin,
//                out_valid/out_ready/S/Cout (and Ovf)
// Optional: PIPE_ADDER_OVF_EN adds the registered signed-overflow output Ovf.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   pipe_adder_if.slave  bus
);
   localparam int unsigned SLICE  = slice_width(WIDTH, STAGES);
   localparam bit          CFG_OK = cfg_ok(WIDTH, STAGES);

   if (!CFG_OK) begin : g_cfg_check
      $error("pipe_adder: WIDTH must be a multiple of STAGES (>=1) and <= MaxWidth");
   end

   stage_t              stage_q [STAGES];
   logic [STAGES-1:0]   valid;
   logic [STAGES-1:0]   adv;
   logic                in_ready;

   // A stage moves its record on when the next stage is empty or moving too;
   // evaluated from the output backwards so in_ready sees the full chain.
   always_comb begin
      adv = '0;
      adv[STAGES-1] = valid[STAGES-1] && bus.out_ready;
      for (int i = int'(STAGES) - 2; i >= 0; i--) begin
         adv[i] = valid[i] && (!valid[i+1] || adv[i+1]);
      end
   end

   assign in_ready     = !valid[0] || adv[0];
   assign bus.in_ready = in_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t           src;
      stage_t           rec_d;
      stage_t           rec_q;
      logic             load;
      logic [SLICE-1:0] a_sl;
      logic [SLICE-1:0] b_sl;
      logic [SLICE-1:0] s_sl;
      logic             c_in;
      logic             c_out;

      if (k == 0) begin : g_first
         assign load = bus.in_valid && in_ready;
         always_comb begin
            src = '0;
            src.opa[WIDTH-1:0] = bus.A;
            src.opb[WIDTH-1:0] = bus.B;
         end
         assign c_in = bus.Cin;
      end else begin : g_rest
         assign load = adv[k-1];
         assign src  = stage_q[k-1];
         assign c_in = stage_q[k-1].carry;
      end

      assign a_sl = src.opa[k*SLICE +: SLICE];
      assign b_sl = src.opb[k*SLICE +: SLICE];

      adder_slice #(
         .WIDTH(SLICE)
      ) u_slice (
         .A   (a_sl),
         .B   (b_sl),
         .Cin (c_in),
         .S   (s_sl),
         .Cout(c_out)
      );

      // Draining without a refill only drops valid; data stays put so the
      // output bus does not glitch between results.
      always_comb begin
         rec_d = rec_q;
         if (load) begin
            rec_d                      = src;
            rec_d.valid                = 1'b1;
            rec_d.carry                = c_out;
            rec_d.sum[k*SLICE +: SLICE] = s_sl;
         end else if (adv[k]) begin
            rec_d.valid = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rec_q <= '0;
         end else begin
            rec_q <= rec_d;
         end
      end

      assign stage_q[k] = rec_q;
      assign valid[k]   = rec_q.valid;

`ifdef PIPE_ADDER_OVF_EN
      // The top slice still sees the operand MSBs, so overflow is resolved
      // alongside the final sum slice.
      if (k == STAGES - 1) begin : g_ovf
         logic ovf_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (load) begin
               ovf_q <= (a_sl[SLICE-1] == b_sl[SLICE-1]) && (s_sl[SLICE-1] != a_sl[SLICE-1]);
            end
         end
         assign bus.Ovf = ovf_q;
      end
`endif
   end

   assign bus.out_valid = valid[STAGES-1];
   assign bus.S         = stage_q[STAGES-1].sum[WIDTH-1:0];
   assign bus.Cout      = stage_q[STAGES-1].carry;

   // Operand copies and padding in the final record have no consumer.
   logic unused_last_stage;
   assign unused_last_stage = ^stage_q[STAGES-1];

endmodule
